// File: rtl/test_monitor_pkg.sv
// Shared types and constants for the end-of-test monitor.
package test_monitor_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SETTLE  = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    localparam int unsigned DEF_DONE_REG = 26;
    localparam int unsigned DEF_PASS_REG = 27;
    localparam int unsigned DEF_TNUM_REG = 3;

    // Ceiling log2, usable in constant expressions such as port widths.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// Circular PC trace: newest-relative read, saturating fill count, freezable.
module pc_trace_buf
    import test_monitor_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rest,
    input  logic                    freeze,
    input  logic                    wr_en,
    input  logic [XLEN-1:0]         wr_pc,
    input  logic [log2c(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]         rd_pc,
    output logic [log2c(DEPTH):0]   cnt
);

    localparam int unsigned IW = log2c(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [IW-1:0]   wp;
    logic [IW-1:0]   rd_addr;
    logic            push;

    assign push = wr_en && !freeze;

    always_ff @(posedge clk) begin
        if (!rest) begin
            wp  <= '0;
            cnt <= '0;
        end else if (push) begin
            wp <= wp + IW'(1);
            if (cnt != (IW+1)'(DEPTH)) cnt <= cnt + (IW+1)'(1);
        end
    end

    // Storage needs no reset: reads beyond the fill count are masked to zero.
    always_ff @(posedge clk) begin
        if (rest && push) mem[wp] <= wr_pc;
    end

    assign rd_addr = wp - rd_idx - IW'(1);

    always_comb begin
        rd_pc = '0;
        if ({1'b0, rd_idx} < cnt) rd_pc = mem[rd_addr];
    end

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: snoops write-back and fetch PC, decides pass/fail/timeout.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DONE_REG       = DEF_DONE_REG,
    parameter int unsigned PASS_REG       = DEF_PASS_REG,
    parameter int unsigned TNUM_REG       = DEF_TNUM_REG,
    parameter int unsigned SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TRACE_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rest,
    input  logic                          wb_en_i,
    input  logic [4:0]                    wb_addr_i,
    input  logic [XLEN-1:0]               wb_data_i,
    input  logic [XLEN-1:0]               pc_i,
    input  logic                          pc_valid_i,
    input  logic [log2c(TRACE_DEPTH)-1:0] trace_idx_i,
    output logic [XLEN-1:0]               trace_pc_o,
    output logic [log2c(TRACE_DEPTH):0]   trace_cnt_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic                          fail_o,
    output logic                          timeout_o,
    output logic [XLEN-1:0]               testnum_o,
    output logic [31:0]                   cycle_cnt_o
);

    state_t      state;
    logic [31:0] settle_cnt;
    logic        pass_flag;
    logic        wr_ok;
    logic        done_wr;
    logic        timeout_hit;
    logic        terminal;
    logic        verdict_now;

    assign wr_ok       = wb_en_i && (wb_addr_i != '0);
    assign done_wr     = wr_ok && (wb_addr_i == 5'(DONE_REG)) && (wb_data_i == XLEN'(1));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt_o == 32'(TIMEOUT_CYCLES - 1));
    assign terminal    = (state == PASS) || (state == FAIL) || (state == TIMEOUT);

    // A zero settle window decides straight from RUN using the pre-edge shadow.
    assign verdict_now = ((state == RUN) && done_wr && (SETTLE_CYCLES == 0)) ||
                         ((state == SETTLE) && (settle_cnt == '0));

    always_ff @(posedge clk) begin
        if (!rest) begin
            state       <= RUN;
            settle_cnt  <= '0;
            pass_flag   <= 1'b0;
            testnum_o   <= '0;
            cycle_cnt_o <= '0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            if (!terminal) begin
                if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 32'd1;
                if (wr_ok && (wb_addr_i == 5'(PASS_REG))) pass_flag <= (wb_data_i == XLEN'(1));
                if (wr_ok && (wb_addr_i == 5'(TNUM_REG))) testnum_o <= wb_data_i;
            end

            if (verdict_now) begin
                state  <= pass_flag ? PASS : FAIL;
                pass_o <= pass_flag;
                fail_o <= !pass_flag;
                done_o <= 1'b1;
            end else if ((state == RUN) && done_wr) begin
                state      <= SETTLE;
                settle_cnt <= 32'(SETTLE_CYCLES - 1);
            end else if ((state == RUN) && timeout_hit) begin
                state     <= TIMEOUT;
                timeout_o <= 1'b1;
                done_o    <= 1'b1;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 32'd1;
            end
        end
    end

    pc_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk    (clk),
        .rest   (rest),
        .freeze (terminal),
        .wr_en  (pc_valid_i),
        .wr_pc  (pc_i),
        .rd_idx (trace_idx_i),
        .rd_pc  (trace_pc_o),
        .cnt    (trace_cnt_o)
    );

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: two configurations driven in lockstep, checked against an event-level model.
module tb_test_monitor;

    logic        clk = 1'b0;
    logic        rest = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic [3:0]  idx0 = '0;
    logic [1:0]  idx1 = '0;

    logic [31:0] tpc0, tpc1, tnum0, tnum1, cyc0, cyc1;
    logic [4:0]  tcnt0;
    logic [2:0]  tcnt1;
    logic        done0, pass0, fail0, to0;
    logic        done1, pass1, fail1, to1;

    always #5 clk = ~clk;

    test_monitor #(
        .XLEN(32), .DONE_REG(26), .PASS_REG(27), .TNUM_REG(3),
        .SETTLE_CYCLES(10), .TIMEOUT_CYCLES(100), .TRACE_DEPTH(16)
    ) u0 (
        .clk(clk), .rest(rest), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .pc_i(pc), .pc_valid_i(pc_valid), .trace_idx_i(idx0), .trace_pc_o(tpc0),
        .trace_cnt_o(tcnt0), .done_o(done0), .pass_o(pass0), .fail_o(fail0),
        .timeout_o(to0), .testnum_o(tnum0), .cycle_cnt_o(cyc0)
    );

    // Second instance: zero settle window, no timeout, tiny trace, test-number register mapped to x0.
    test_monitor #(
        .XLEN(32), .DONE_REG(26), .PASS_REG(27), .TNUM_REG(0),
        .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(0), .TRACE_DEPTH(4)
    ) u1 (
        .clk(clk), .rest(rest), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .pc_i(pc), .pc_valid_i(pc_valid), .trace_idx_i(idx1), .trace_pc_o(tpc1),
        .trace_cnt_o(tcnt1), .done_o(done1), .pass_o(pass1), .fail_o(fail1),
        .timeout_o(to1), .testnum_o(tnum1), .cycle_cnt_o(cyc1)
    );

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int settle_of(int k);   return (k == 0) ? 10 : 0;  endfunction
    function automatic int timeout_of(int k);  return (k == 0) ? 100 : 0; endfunction
    function automatic int depth_of(int k);    return (k == 0) ? 16 : 4;  endfunction
    function automatic int tnumreg_of(int k);  return (k == 0) ? 3 : 0;   endfunction

    int          m_cyc [2];
    int          m_done_at [2];
    bit          m_term [2], m_pass [2], m_fail [2], m_to [2], m_flag [2];
    logic [31:0] m_tnum [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    // Verdict happens at the edge index done_at+N; timeout at edge index TIMEOUT-1.
    always @(posedge clk) begin
        int n;
        bit wr;
        for (int k = 0; k < 2; k++) begin
            if (!rest) begin
                m_cyc[k] = 0; m_done_at[k] = -1; m_term[k] = 0;
                m_pass[k] = 0; m_fail[k] = 0; m_to[k] = 0; m_flag[k] = 0; m_tnum[k] = '0;
                if (k == 0) q0.delete(); else q1.delete();
            end else if (!m_term[k]) begin
                n  = m_cyc[k];
                wr = wb_en && (wb_addr != 0);
                if (m_done_at[k] < 0 && wr && wb_addr == 26 && wb_data == 1) m_done_at[k] = n;
                if (m_done_at[k] >= 0 && n == m_done_at[k] + settle_of(k)) begin
                    m_term[k] = 1; m_pass[k] = m_flag[k]; m_fail[k] = !m_flag[k];
                end else if (m_done_at[k] < 0 && timeout_of(k) != 0 && n == timeout_of(k) - 1) begin
                    m_term[k] = 1; m_to[k] = 1;
                end
                if (wr && wb_addr == 27) m_flag[k] = (wb_data == 1);
                if (wr && int'(wb_addr) == tnumreg_of(k)) m_tnum[k] = wb_data;
                if (pc_valid) begin
                    if (k == 0) begin
                        q0.push_front(pc);
                        if (q0.size() > depth_of(0)) void'(q0.pop_back());
                    end else begin
                        q1.push_front(pc);
                        if (q1.size() > depth_of(1)) void'(q1.pop_back());
                    end
                end
                m_cyc[k] = n + 1;
            end
        end
    end

    function automatic logic [31:0] exp_trace(int k, int idx);
        if (k == 0) return (idx < q0.size()) ? q0[idx] : 32'd0;
        return (idx < q1.size()) ? q1[idx] : 32'd0;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("u0.done",    32'(done0), 32'(m_term[0]));
            chk("u0.pass",    32'(pass0), 32'(m_pass[0]));
            chk("u0.fail",    32'(fail0), 32'(m_fail[0]));
            chk("u0.timeout", 32'(to0),   32'(m_to[0]));
            chk("u0.testnum", tnum0,      m_tnum[0]);
            chk("u0.cycle",   cyc0,       32'(m_cyc[0]));
            chk("u0.tcnt",    32'(tcnt0), 32'(q0.size()));
            chk("u0.tpc",     tpc0,       exp_trace(0, int'(idx0)));
            chk("u1.done",    32'(done1), 32'(m_term[1]));
            chk("u1.pass",    32'(pass1), 32'(m_pass[1]));
            chk("u1.fail",    32'(fail1), 32'(m_fail[1]));
            chk("u1.timeout", 32'(to1),   32'(m_to[1]));
            chk("u1.testnum", tnum1,      m_tnum[1]);
            chk("u1.cycle",   cyc1,       32'(m_cyc[1]));
            chk("u1.tcnt",    32'(tcnt1), 32'(q1.size()));
            chk("u1.tpc",     tpc1,       exp_trace(1, int'(idx1)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        wb_en = 0; pc_valid = 0;
        repeat (n) step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d; pc_valid = 0;
        step();
        wb_en = 0;
    endtask

    task automatic do_reset();
        rest = 0; wb_en = 0; pc_valid = 0;
        step();
        rest = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " u0 outs"}, {done0, pass0, fail0, to0, 28'd0}, 32'd0);
        chk({tag, " u0 cycle"}, cyc0, 32'd0);
        chk({tag, " u0 testnum"}, tnum0, 32'd0);
        chk({tag, " u0 tcnt"}, 32'(tcnt0), 32'd0);
        chk({tag, " u0 tpc"}, tpc0, 32'd0);
        chk({tag, " u1 outs"}, {done1, pass1, fail1, to1, 28'd0}, 32'd0);
        chk({tag, " u1 cycle"}, cyc1, 32'd0);
    endtask

    initial begin
        step();
        checking = 1;
        do_reset();
        chk_all_zero("reset");

        // x27=1, then done at edge 20: u1 decides at once, u0 after ten more edges.
        wr(27, 1); idle(19); wr(26, 1);
        chk("A u1 pass", 32'(pass1), 32'd1);
        chk("A u1 cycle", cyc1, 32'd21);
        idle(9);
        chk("A u0 not yet", 32'(done0), 32'd0);
        idle(1);
        chk("A u0 pass", {done0, pass0, fail0, to0}, 32'b1100);
        chk("A u0 cycle", cyc0, 32'd31);

        do_reset();
        chk_all_zero("reset from PASS");

        wr(3, 5); wr(27, 0); wr(26, 1); idle(10);
        chk("B u0 fail", {done0, pass0, fail0, to0}, 32'b1010);
        chk("B u0 testnum", tnum0, 32'd5);
        chk("B u1 fail", 32'(fail1), 32'd1);
        chk("B u1 testnum x0", tnum1, 32'd0);
        wr(3, 9);
        chk("B u0 testnum frozen", tnum0, 32'd5);
        chk("B u0 cycle frozen", cyc0, 32'd13);

        do_reset();
        wr(26, 1); idle(2); wr(27, 1); idle(7);
        chk("C u0 late pass", 32'(pass0), 32'd1);
        chk("C u1 fail", {done1, pass1, fail1}, 32'b101);

        do_reset();
        wr(26, 0); idle(12);
        chk("D0 u0 no done", 32'(done0), 32'd0);
        chk("D0 u1 no done", 32'(done1), 32'd0);

        do_reset();
        idle(99);
        chk("T u0 pre", 32'(done0), 32'd0);
        idle(1);
        chk("T u0 timeout", {done0, pass0, fail0, to0}, 32'b1001);
        chk("T u0 cycle", cyc0, 32'd100);
        idle(5);
        chk("T u0 cycle frozen", cyc0, 32'd100);
        chk("T u1 running", cyc1, 32'd105);

        do_reset();
        idle(99); wr(26, 1);
        chk("T2 u0 no timeout", {done0, to0}, 32'd0);
        idle(10);
        chk("T2 u0 fail", {done0, pass0, fail0, to0}, 32'b1010);
        chk("T2 u0 cycle", cyc0, 32'd110);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            pc_valid = 1; pc = 32'(4 * i);
            step();
        end
        pc_valid = 0;
        chk("E u0 tcnt", 32'(tcnt0), 32'd16);
        chk("E u1 tcnt", 32'(tcnt1), 32'd4);
        idx0 = 0; idx1 = 0; #1;
        chk("E u0 idx0", tpc0, 32'h4C);
        chk("E u1 idx0", tpc1, 32'h4C);
        idx0 = 15; idx1 = 3; #1;
        chk("E u0 idx15", tpc0, 32'h10);
        chk("E u1 idx3", tpc1, 32'h40);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            pc_valid = 1; pc = 32'h100 + 32'(4 * i);
            step();
        end
        pc_valid = 0;
        idx0 = 5; idx1 = 3; #1;
        chk("E2 u0 idx5", tpc0, 32'd0);
        chk("E2 u1 idx3", tpc1, 32'd0);
        idx0 = 2; idx1 = 0; #1;
        chk("E2 u0 idx2", tpc0, 32'h100);
        chk("E2 u1 idx0", tpc1, 32'h108);

        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            repeat ($urandom_range(40, 160)) begin
                rest  = ($urandom_range(0, 99) != 0);
                wb_en = ($urandom_range(0, 9) < 4);
                case ($urandom_range(0, 9))
                    0:       wb_addr = 5'd0;
                    1:       wb_addr = 5'd3;
                    2, 3:    wb_addr = 5'd26;
                    4, 5:    wb_addr = 5'd27;
                    default: wb_addr = 5'($urandom);
                endcase
                case ($urandom_range(0, 2))
                    0:       wb_data = 32'd0;
                    1:       wb_data = 32'd1;
                    default: wb_data = $urandom;
                endcase
                pc_valid = $urandom_range(0, 1) == 1;
                pc   = $urandom & 32'hFFFF_FFFC;
                idx0 = 4'($urandom);
                idx1 = 2'($urandom);
                step();
            end
            rest = 1;
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
